// File: rtl/ame_pkg.sv
// Shared types and helpers for the AME determinant/divide datapath.
package ame_pkg;

  // Default width of the signed comp word travelling between AME stages.
  localparam int COMP_DATA_BITS_DFLT = 64;

  typedef logic signed [COMP_DATA_BITS_DFLT-1:0] comp_word_t;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of quotient bits produced: the integer part plus the fractional part.
  function automatic int div_bits(input int data_bits, input int frac_bits);
    return data_bits + frac_bits;
  endfunction

endpackage

// File: rtl/ame_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module ame_div_step #(
  parameter int COMP_DATA_BITS = 64
) (
  input  logic [COMP_DATA_BITS:0]   rem_i,
  input  logic                      bit_i,
  input  logic [COMP_DATA_BITS-1:0] dvs_i,
  output logic [COMP_DATA_BITS:0]   rem_o,
  output logic                      q_o
);

  logic [COMP_DATA_BITS:0] rem_sh;

  // A set bit shifted out of the remainder means the shifted value certainly exceeds the
  // divisor; the modular subtraction still leaves the correct (smaller) remainder.
  always_comb begin
    rem_sh = {rem_i[COMP_DATA_BITS-1:0], bit_i};
    q_o    = rem_i[COMP_DATA_BITS] | (rem_sh >= {1'b0, dvs_i});
    rem_o  = q_o ? (rem_sh - {1'b0, dvs_i}) : rem_sh;
  end

endmodule

// File: rtl/ame_det_divide.sv
// Cramer's-rule divider: signed N / D -> fixed-point affine motion parameter.
// Iterative radix-2 restoring division with sign handling, divide-by-zero and saturation.
module ame_det_divide
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int FRAC_BITS      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           comp_init_i,
  input  logic [1:0][COMP_DATA_BITS-1:0] comp_data_i,
  output logic                           comp_busy_o,
  output logic                           comp_done_o,
  output logic                           comp_zero_o,
  output logic                           comp_sat_o,
  output logic [COMP_DATA_BITS-1:0]      comp_data_o
);

  localparam int W     = COMP_DATA_BITS;
  localparam int DB    = div_bits(COMP_DATA_BITS, FRAC_BITS);
  localparam int CNT_W = (DB > 1) ? $clog2(DB) : 1;

  localparam logic [DB:0]  LIM_NEG = (DB+1)'(1) << (W-1);
  localparam logic [DB:0]  LIM_POS = LIM_NEG - (DB+1)'(1);
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  div_state_t state_q, state_d;

  logic signed [W-1:0] num_s, den_s;
  logic                den_zero;

  logic             sign_q;
  logic             zero_q;
  logic [DB-1:0]    dvd_q;
  logic [W-1:0]     dvs_q;
  logic [W:0]       rem_q;
  logic [DB-1:0]    quo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W:0] rem_nxt;
  logic       q_bit;
  logic [W:0] sat_res;

  // Magnitude of a two's-complement word; the most negative value maps exactly to 2^(W-1).
  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  // Clamp the truncated magnitude to the signed range and apply the sign.
  // Result is {saturated, value}.
  function automatic logic [W:0] saturate(input logic neg, input logic [DB-1:0] mag);
    logic [DB:0]  m;
    logic [W-1:0] mw;
    m  = {1'b0, mag};
    mw = mag[W-1:0];
    if (!neg && (m > LIM_POS)) return {1'b1, MAX_POS};
    if (neg && (m > LIM_NEG))  return {1'b1, MIN_NEG};
    return {1'b0, neg ? (~mw + 1'b1) : mw};
  endfunction

  assign num_s    = comp_data_i[1];
  assign den_s    = comp_data_i[0];
  assign den_zero = (den_s == '0);

  ame_div_step #(
    .COMP_DATA_BITS(COMP_DATA_BITS)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DB-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: init is honoured only in IDLE; zero divisor skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (comp_init_i) state_d = den_zero ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accepted init, then one quotient bit per CALC cycle, MSB first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else if ((state_q == IDLE) && comp_init_i) begin
      sign_q <= num_s[W-1] ^ den_s[W-1];
      zero_q <= den_zero;
      dvd_q  <= DB'(abs_val(num_s)) << FRAC_BITS;
      dvs_q  <= abs_val(den_s);
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= CNT_W'(DB-1);
    end else if (state_q == CALC) begin
      rem_q <= rem_nxt;
      dvd_q <= dvd_q << 1;
      quo_q <= (quo_q << 1) | DB'(q_bit);
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Outputs: result fields are driven only during the single DONE cycle.
  always_comb begin
    comp_busy_o = (state_q != IDLE);
    comp_done_o = 1'b0;
    comp_zero_o = 1'b0;
    comp_sat_o  = 1'b0;
    comp_data_o = '0;
    sat_res     = saturate(sign_q, quo_q);
    if (state_q == DONE) begin
      comp_done_o = 1'b1;
      if (zero_q) begin
        comp_zero_o = 1'b1;
      end else begin
        comp_sat_o  = sat_res[W];
        comp_data_o = sat_res[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ame_det_divide.sv
// Bench for ame_det_divide: 16-bit instances with FRAC_BITS=0 and FRAC_BITS=4.
module tb_ame_det_divide;

  logic clk;
  logic rst_n;

  logic              init0, init4;
  logic [1:0][15:0]  din0, din4;
  logic              busy0, done0, zero0, sat0;
  logic              busy4, done4, zero4, sat4;
  logic signed [15:0] dout0, dout4;

  logic              sel;
  logic              c_busy, c_done, c_zero, c_sat;
  logic signed [15:0] c_data;

  int checks = 0;
  int errors = 0;

  ame_det_divide #(.COMP_DATA_BITS(16), .FRAC_BITS(0)) u_f0 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init0), .comp_data_i(din0),
    .comp_busy_o(busy0), .comp_done_o(done0), .comp_zero_o(zero0),
    .comp_sat_o(sat0), .comp_data_o(dout0)
  );

  ame_det_divide #(.COMP_DATA_BITS(16), .FRAC_BITS(4)) u_f4 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init4), .comp_data_i(din4),
    .comp_busy_o(busy4), .comp_done_o(done4), .comp_zero_o(zero4),
    .comp_sat_o(sat4), .comp_data_o(dout4)
  );

  assign c_busy = sel ? busy4 : busy0;
  assign c_done = sel ? done4 : done0;
  assign c_zero = sel ? zero4 : zero0;
  assign c_sat  = sel ? sat4  : sat0;
  assign c_data = sel ? dout4 : dout0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scale N by 2^f, divide with truncation toward zero, clamp to 16-bit signed.
  task automatic model(input int f, input logic signed [15:0] n, input logic signed [15:0] d,
                       output logic signed [15:0] q, output logic z, output logic s);
    longint num, r;
    if (d == 0) begin
      q = 0; z = 1'b1; s = 1'b0;
    end else begin
      num = longint'(n) * (longint'(1) << f);
      r   = num / longint'(d);
      z   = 1'b0;
      if (r > 32767)       begin q = 16'sh7fff; s = 1'b1; end
      else if (r < -32768) begin q = 16'sh8000; s = 1'b1; end
      else                 begin q = 16'(r);    s = 1'b0; end
    end
  endtask

  // Drives one operation from the current cycle (called at posedge+1) and observes it.
  // lat counts cycles from the init sample cycle; busy_n counts busy cycles including
  // the cycle after done; dirty counts cycles before done with non-zero result fields.
  task automatic run_op(input int f, input logic signed [15:0] n, input logic signed [15:0] d,
                        output logic signed [15:0] q, output logic z, output logic s,
                        output int lat, output int busy_n, output int dirty);
    sel = (f != 0);
    if (f == 0) begin din0[1] = n; din0[0] = d; init0 = 1'b1; end
    else        begin din4[1] = n; din4[0] = d; init4 = 1'b1; end
    @(posedge clk); #1;
    init0 = 1'b0; init4 = 1'b0;
    lat = 1; busy_n = 0; dirty = 0;
    while (1) begin
      if (c_busy) busy_n++;
      if (c_done) break;
      if (c_data != 0 || c_zero || c_sat) dirty++;
      if (lat >= 200) break;
      @(posedge clk); #1;
      lat++;
    end
    q = c_data; z = c_zero; s = c_sat;
    @(posedge clk); #1;
    if (c_busy) busy_n++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy0, done0, zero0, sat0, dout0} !== 20'h0) begin
      errors++;
      $display("FAIL reset_f0: got %h expected 0", {busy0, done0, zero0, sat0, dout0});
    end
    checks++;
    if ({busy4, done4, zero4, sat4, dout4} !== 20'h0) begin
      errors++;
      $display("FAIL reset_f4: got %h expected 0", {busy4, done4, zero4, sat4, dout4});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int f_t[10]             = '{0, 0, 0, 0, 0, 0, 0, 4, 4, 4};
    logic signed [15:0] n_t[10] = '{100, -100, 100, -100, -32768, -32768, 0, 3, -1, 32767};
    logic signed [15:0] d_t[10] = '{7, 7, -7, -7, 1, -1, 5, 2, 3, 1};
    logic signed [15:0] q, eq;
    logic z, s, ez, es;
    int lat, bn, dirty;
    for (int i = 0; i < 10; i++) begin
      run_op(f_t[i], n_t[i], d_t[i], q, z, s, lat, bn, dirty);
      model(f_t[i], n_t[i], d_t[i], eq, ez, es);
      checks++;
      if (q !== eq || z !== ez || s !== es) begin
        errors++;
        $display("FAIL directed_%0d (%0d/%0d f=%0d): got q=%0d z=%0b s=%0b expected q=%0d z=%0b s=%0b",
                 i, n_t[i], d_t[i], f_t[i], q, z, s, eq, ez, es);
      end
      checks++;
      if (lat != 17 + f_t[i] || bn != 17 + f_t[i] || dirty != 0) begin
        errors++;
        $display("FAIL directed_timing_%0d: got lat=%0d busy=%0d dirty=%0d expected lat=%0d busy=%0d dirty=0",
                 i, lat, bn, dirty, 17 + f_t[i], 17 + f_t[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic signed [15:0] q;
    logic z, s;
    int lat, bn, dirty;
    for (int f = 0; f <= 4; f += 4) begin
      run_op(f, 16'sd55, 16'sd0, q, z, s, lat, bn, dirty);
      checks++;
      if (q !== 16'sd0 || z !== 1'b1 || s !== 1'b0 || lat != 1 || bn != 1) begin
        errors++;
        $display("FAIL div_zero_f%0d: got q=%0d z=%0b s=%0b lat=%0d busy=%0d expected q=0 z=1 s=0 lat=1 busy=1",
                 f, q, z, s, lat, bn);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] n, d, q, eq;
    logic z, s, ez, es;
    int lat, bn, dirty, f;
    for (int i = 0; i < 50; i++) begin
      f = (i % 2 == 0) ? 0 : 4;
      n = 16'($urandom);
      case ($urandom_range(0, 9))
        0: d = 16'sd0;
        1: d = -16'sd1;
        2: d = 16'sd1;
        3: d = 16'sh8000;
        4: d = 16'($urandom_range(1, 15));
        default: d = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 1) ? 16'sh8000 : 16'sh7fff;
      run_op(f, n, d, q, z, s, lat, bn, dirty);
      model(f, n, d, eq, ez, es);
      checks++;
      if (q !== eq || z !== ez || s !== es || lat != ((d == 0) ? 1 : 17 + f)) begin
        errors++;
        $display("FAIL random_%0d (%0d/%0d f=%0d): got q=%0d z=%0b s=%0b lat=%0d expected q=%0d z=%0b s=%0b",
                 i, n, d, f, q, z, s, lat, eq, ez, es);
      end
    end
  endtask

  task automatic test_ignored_init();
    int cyc, ndone, lat;
    logic signed [15:0] q;
    sel = 1'b0;
    din0[1] = 16'sd100; din0[0] = 16'sd7; init0 = 1'b1;
    @(posedge clk); #1;
    init0 = 1'b0;
    cyc = 1; ndone = 0; lat = 0; q = 0;
    while (cyc <= 40) begin
      if (cyc == 5) begin din0[1] = 16'sd9; din0[0] = 16'sd3; init0 = 1'b1; end
      else init0 = 1'b0;
      if (done0) begin ndone++; q = dout0; lat = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    init0 = 1'b0;
    checks++;
    if (ndone != 1 || q !== 16'sd14 || lat != 17) begin
      errors++;
      $display("FAIL ignored_init: got dones=%0d q=%0d lat=%0d expected dones=1 q=14 lat=17", ndone, q, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] q1, q2, e1, e2;
    logic z, s, ez, es;
    int lat1, lat2, bn, dirty;
    run_op(0, 16'sd100, 16'sd7, q1, z, s, lat1, bn, dirty);
    run_op(0, -16'sd9, 16'sd4, q2, z, s, lat2, bn, dirty);
    model(0, 16'sd100, 16'sd7, e1, ez, es);
    model(0, -16'sd9, 16'sd4, e2, ez, es);
    checks++;
    if (q1 !== e1 || q2 !== e2 || lat2 != 17) begin
      errors++;
      $display("FAIL back_to_back_f0: got q1=%0d q2=%0d lat2=%0d expected q1=%0d q2=%0d lat2=17",
               q1, q2, lat2, e1, e2);
    end
    run_op(4, 16'sd5, 16'sd3, q1, z, s, lat1, bn, dirty);
    run_op(4, -16'sd7, 16'sd2, q2, z, s, lat2, bn, dirty);
    model(4, 16'sd5, 16'sd3, e1, ez, es);
    model(4, -16'sd7, 16'sd2, e2, ez, es);
    checks++;
    if (q1 !== e1 || q2 !== e2 || lat2 != 21) begin
      errors++;
      $display("FAIL back_to_back_f4: got q1=%0d q2=%0d lat2=%0d expected q1=%0d q2=%0d lat2=21",
               q1, q2, lat2, e1, e2);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, late_dones, lat, bn, dirty;
    logic signed [15:0] q;
    logic z, s;
    sel = 1'b0;
    din0[1] = 16'sd100; din0[0] = 16'sd7; init0 = 1'b1;
    @(posedge clk); #1;
    init0 = 1'b0;
    cyc = 1;
    while (cyc < 8) begin @(posedge clk); #1; cyc++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, zero0, sat0, dout0} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {busy0, done0, zero0, sat0, dout0});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    late_dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done0 || busy0) late_dones++;
    end
    checks++;
    if (late_dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", late_dones);
    end
    run_op(0, 16'sd9, 16'sd3, q, z, s, lat, bn, dirty);
    checks++;
    if (q !== 16'sd3 || z !== 1'b0 || s !== 1'b0 || lat != 17) begin
      errors++;
      $display("FAIL reset_mid_recover: got q=%0d z=%0b s=%0b lat=%0d expected q=3 z=0 s=0 lat=17",
               q, z, s, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    init0 = 1'b0; init4 = 1'b0;
    din0 = '0; din4 = '0;
    sel = 1'b0;
    test_reset();
    test_directed();
    test_div_zero();
    test_ignored_init();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
